// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the fetch/pipeline controller: next-PC select codes,
// FSM state encoding and redirect-target helpers.
package pipe_ctrl_pkg;

   localparam logic [1:0]  PC_SEQ = 2'b00;
   localparam logic [1:0]  PC_JAL = 2'b01;
   localparam logic [1:0]  PC_BR  = 2'b10;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_BOOT      = 2'b00,
      ST_RUN       = 2'b01,
      ST_IMEM_WAIT = 2'b10
   } state_t;

   // Redirect targets are word-aligned by dropping the two low bits.
   function automatic logic [31:0] align_tgt(input logic [31:0] tgt);
      return {tgt[31:2], 2'b00};
   endfunction

   function automatic logic is_misaligned(input logic [31:0] tgt);
      return (tgt[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Fetch-stage PC sequencing, F/D and D/E bubble control, per-stage valid
// tracking and stall/flush performance counting.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_BOOT      | first cycle after reset, no fetch issued
//   ST_RUN       | fetch request outstanding, last fetch returned/stalled
//   ST_IMEM_WAIT | fetch request outstanding, instruction memory missed
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             flush,
   input  logic [1:0]       pc_sel,
   input  logic [31:0]      jal_tgt,
   input  logic [31:0]      br_tgt,
   input  logic [31:0]      jalr_tgt,
   input  logic             imem_valid,
   output logic [31:0]      pc,
   output logic             imem_req,
   output logic             fd_en,
   output logic             fd_bubble,
   output logic             de_bubble,
   output logic             v_d,
   output logic             v_e,
   output logic             v_m,
   output logic             v_w,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             misalign
);

   state_t      state;
   logic        f_fire;
   logic        redirect;
   logic [31:0] redirect_tgt;
   logic [31:0] pc_next;

   always_comb begin
      f_fire    = (state != ST_BOOT) && imem_valid && !stall && !flush;
      imem_req  = 1'b0;
      fd_en     = 1'b0;
      fd_bubble = 1'b1;
      de_bubble = 1'b0;
      if (state != ST_BOOT) begin
         imem_req = 1'b1;
         if (stall) begin
            fd_en     = 1'b0;
            fd_bubble = 1'b0;
            de_bubble = 1'b1;
         end else if (flush) begin
            fd_en     = 1'b1;
            fd_bubble = 1'b1;
         end else if (imem_valid) begin
            fd_en     = 1'b1;
            fd_bubble = 1'b0;
         end else begin
            fd_en     = 1'b1;
            fd_bubble = 1'b1;
         end
      end
   end

   // A JALR flush wins over any PC_SEL redirect of the instruction in fetch.
   always_comb begin
      redirect     = 1'b0;
      redirect_tgt = jalr_tgt;
      if ((state != ST_BOOT) && !stall) begin
         if (flush) begin
            redirect     = 1'b1;
            redirect_tgt = jalr_tgt;
         end else if (imem_valid) begin
            case (pc_sel)
               PC_JAL: begin
                  redirect     = 1'b1;
                  redirect_tgt = jal_tgt;
               end
               PC_BR: begin
                  redirect     = 1'b1;
                  redirect_tgt = br_tgt;
               end
               default: begin
                  redirect     = 1'b0;
                  redirect_tgt = jalr_tgt;
               end
            endcase
         end
      end
      pc_next = pc;
      if (redirect) begin
         pc_next = align_tgt(redirect_tgt);
      end else if (f_fire) begin
         pc_next = pc + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_BOOT;
         pc       <= RESET_VEC;
         v_d      <= 1'b0;
         v_e      <= 1'b0;
         v_m      <= 1'b0;
         v_w      <= 1'b0;
         misalign <= 1'b0;
      end else begin
         pc  <= pc_next;
         v_m <= v_e;
         v_w <= v_m;
         if (redirect && is_misaligned(redirect_tgt)) begin
            misalign <= 1'b1;
         end
         case (state)
            ST_BOOT: begin
               state <= ST_RUN;
               v_d   <= 1'b0;
               v_e   <= v_d;
            end
            default: begin
               state <= (imem_valid || stall) ? ST_RUN : ST_IMEM_WAIT;
               if (stall) begin
                  v_e <= 1'b0;
               end else begin
                  v_e <= v_d;
                  v_d <= f_fire;
               end
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush && !stall),
      .count (flush_cnt)
   );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter CNT_W, default 16, is the width of each performance counter.
REQ-003 The block has one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  is the single clock; all state updates on its rising edge.
REQ-005 RST_N  in  1  is the asynchronous active-low reset.
REQ-006 STALL  in  1  is the load-use stall request from the hazard unit.
REQ-007 FLUSH  in  1  is the JALR-in-decode redirect request from the hazard unit.
REQ-008 PC_SEL  in  2  selects the next PC: 00 sequential, 01 JAL_TGT, 10 BR_TGT, 11 reserved and treated as 00.
REQ-009 JAL_TGT, BR_TGT, JALR_TGT  in  32 each  are the redirect targets.
REQ-010 IMEM_VALID  in  1  means the instruction for the presented PC is returned this cycle.
REQ-011 PC  out  32  is the fetch address (registered).
REQ-012 IMEM_REQ  out  1  is the fetch request for PC.
REQ-013 FD_EN  out  1  is the F/D pipeline-register load enable.
REQ-014 FD_BUBBLE  out  1  clears the F/D register to a NOP.
REQ-015 DE_BUBBLE  out  1  clears the D/E register to a NOP.
REQ-016 V_D, V_E, V_M, V_W  out  1 each  are the per-stage valid bits.
REQ-017 STALL_CNT, FLUSH_CNT  out  CNT_W each  are the performance counters.
REQ-018 MISALIGN  out  1  is a sticky flag for a redirect target with bits [1:0] != 0.

Function
REQ-019 The FSM has three states:
- BOOT: IMEM_REQ=0, no fetch, FD_BUBBLE=1; always goes to RUN on the next cycle.
- RUN: IMEM_REQ=1.
- IMEM_WAIT: IMEM_REQ=1.
REQ-020 In RUN or IMEM_WAIT, the next state is RUN when IMEM_VALID=1 or STALL=1, and IMEM_WAIT otherwise.
REQ-021 Request priority per cycle is STALL > FLUSH > IMEM miss > PC_SEL; STALL and FLUSH together is treated as STALL only.
REQ-022 STALL: PC holds, FD_EN=0, FD_BUBBLE=0, DE_BUBBLE=1, V_D holds, V_E<=0.
REQ-023 FLUSH: PC<=JALR_TGT, FD_EN=1, FD_BUBBLE=1, V_D<=0; the JALR proceeds to E with V_E<=V_D.
REQ-024 Fetch fire (F_FIRE) is: state != BOOT, IMEM_VALID=1, STALL=0, FLUSH=0.
REQ-025 On F_FIRE: FD_EN=1, FD_BUBBLE=0, V_D<=1, and PC updates per PC_SEL; sequential is PC+4 modulo 2^32.
REQ-026 No fetch and no STALL/FLUSH (miss or BOOT): PC holds, FD_EN=1, FD_BUBBLE=1, V_D<=0.
REQ-027 When not stalling, V_E<=V_D; V_M<=V_E and V_W<=V_M every cycle unconditionally.
REQ-028 Any redirect (JAL, branch or JALR) loads the target with bits [1:0] forced to 0 and sets MISALIGN if the original bits were nonzero; MISALIGN clears only on reset.
REQ-029 STALL_CNT increments each cycle STALL=1, and FLUSH_CNT each cycle FLUSH=1 && STALL=0; both saturate at all-ones with no wrap.
REQ-030 FD_EN, FD_BUBBLE, DE_BUBBLE and IMEM_REQ are combinational from state and inputs; all other outputs are registered.
REQ-031 FLUSH during IMEM_WAIT redirects PC and abandons the pending fetch; the state stays IMEM_WAIT until IMEM_VALID=1.

Reset
REQ-032 RST_N low asynchronously forces:
- PC=RESET_VEC, state=BOOT
- V_D=V_E=V_M=V_W=0
- STALL_CNT=FLUSH_CNT=0, MISALIGN=0
REQ-033 During reset and in BOOT: IMEM_REQ=0, FD_EN=0, FD_BUBBLE=1, DE_BUBBLE=0.
REQ-034 Reset asserted mid-stall or mid-redirect discards all pending state; no partial PC update is visible after reset release.

Structure
REQ-035 The shared package holds the PC_SEL encodings (PC_SEQ, PC_JAL, PC_BR), the FSM state enum, and the default RESET_VEC.
REQ-036 A sub-module sat_counter (parameterised width, increment enable, saturating) is instantiated twice, for STALL_CNT and FLUSH_CNT.

Verification
REQ-037 Reset release with IMEM_VALID=1 and PC_SEL=00 -> cycle 1 BOOT with PC=0 and IMEM_REQ=0; then PC steps 0,4,8; V_D rises one cycle after the first fetch and V_W four cycles after.
REQ-038 STALL=1 for 2 cycles at PC=0x10 -> PC holds 0x10, FD_EN=0, DE_BUBBLE=1 for both cycles, two V_E holes propagate to V_W, STALL_CNT=2.
REQ-039 FLUSH=1 with JALR_TGT=0x200 -> next PC=0x200, V_D=0 for one cycle, V_E=1 (JALR retained), FLUSH_CNT=1.
REQ-040 PC_SEL=01 with JAL_TGT=0x103 -> PC=0x100, MISALIGN=1 and stays 1 until RST_N low.
REQ-041 IMEM_VALID=0 for 3 cycles, with FLUSH (JALR_TGT=0x40) in cycle 2 -> IMEM_WAIT, FD_BUBBLE=1 each cycle, PC=0x40 from cycle 3, RUN after IMEM_VALID returns.
REQ-042 STALL and FLUSH asserted together; STALL held 2^CNT_W+5 cycles -> stall behaviour only with PC unchanged, FLUSH_CNT unchanged, STALL_CNT saturated at all-ones.
